// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller slice.
package sseg_pkg;

  localparam int N_DIGITS = 8;
  localparam int SEL_W    = 3;
  localparam int HEX_W    = 4;

  localparam logic WR_DIRECT = 1'b0;
  localparam logic WR_SHIFT  = 1'b1;

  typedef struct packed {
    logic             valid;
    logic             dp;
    logic [HEX_W-1:0] hex;
  } sseg_entry_t;

  localparam sseg_entry_t ENTRY_RESET = '0;

  // Every accepted write produces a valid entry; only clear/reset drop validity.
  function automatic sseg_entry_t make_entry(input logic dp, input logic [HEX_W-1:0] hex);
    sseg_entry_t e;
    e.valid = 1'b1;
    e.dp    = dp;
    e.hex   = hex;
    return e;
  endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Free-running dwell counter; tick marks the last clock of each dwell period.
module sseg_prescaler #(
  parameter int PRESCALE_BITS = 17
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [PRESCALE_BITS-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count + PRESCALE_BITS'(1);
    end
  end

  assign tick = (count == '1);

endmodule

// File: rtl/sseg_scan_controller.sv
// Eight-digit frame buffer with direct/shift write port, time-multiplexed onto
// the seven-segment driver inputs with a short anti-ghosting blank after each step.
module sseg_scan_controller
  import sseg_pkg::*;
#(
  parameter int PRESCALE_BITS = 17,
  parameter int BLANK_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             wr_mode,
  input  logic [SEL_W-1:0] wr_addr,
  input  logic [HEX_W-1:0] wr_data,
  input  logic             wr_dp,
  output logic [HEX_W-1:0] digit_hex,
  output logic [SEL_W-1:0] digit_sel,
  output logic             digit_dp,
  output logic             digit_en
);

  localparam logic [PRESCALE_BITS-1:0] BLANK_LOAD = PRESCALE_BITS'(BLANK_CYCLES);

  sseg_entry_t              entries [N_DIGITS];
  sseg_entry_t              wr_entry;
  sseg_entry_t              cur_entry;
  logic                     tick;
  logic                     wr_fire;
  logic [SEL_W-1:0]         scan_idx;
  logic [PRESCALE_BITS-1:0] blank_cnt;
  logic [PRESCALE_BITS-1:0] blank_nxt;

  sseg_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // clear takes priority, so a colliding write is refused rather than silently lost.
  assign wr_ready  = ~reset & ~clear;
  assign wr_fire   = wr_valid & wr_ready;
  assign wr_entry  = make_entry(wr_dp, wr_data);
  assign cur_entry = entries[scan_idx];

  always_comb begin
    blank_nxt = '0;
    if (tick) begin
      blank_nxt = BLANK_LOAD;
    end else if (blank_cnt != '0) begin
      blank_nxt = blank_cnt - PRESCALE_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        entries[i] <= ENTRY_RESET;
      end
    end else if (clear) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else if (wr_fire) begin
      if (wr_mode == WR_SHIFT) begin
        for (int i = 1; i < N_DIGITS; i++) begin
          entries[i] <= entries[i-1];
        end
        entries[0] <= wr_entry;
      end else begin
        entries[wr_addr] <= wr_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx  <= '0;
      blank_cnt <= '0;
    end else begin
      if (tick) begin
        scan_idx <= scan_idx + SEL_W'(1);
      end
      blank_cnt <= blank_nxt;
    end
  end

  // Outputs sample pre-write storage, so a write shows up one clock after it lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_sel <= '0;
      digit_hex <= '0;
      digit_dp  <= 1'b0;
      digit_en  <= 1'b0;
    end else begin
      digit_sel <= scan_idx;
      digit_hex <= cur_entry.hex;
      digit_dp  <= cur_entry.dp;
      digit_en  <= cur_entry.valid & (blank_nxt == '0);
    end
  end

  blank_shorter_than_dwell: assert property (@(posedge clk) BLANK_CYCLES < (2 ** PRESCALE_BITS));

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with a small model of what the driver would display.
module tb_sseg_scan_controller;
  import sseg_pkg::*;

  localparam int PB = 3;
  localparam int BC = 1;

  typedef struct packed {
    logic       en;
    logic [3:0] hex;
    logic       dp;
  } frame_vec_t;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       clear    = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_mode  = 1'b0;
  logic [2:0] wr_addr  = 3'd0;
  logic [3:0] wr_data  = 4'd0;
  logic       wr_dp    = 1'b0;
  logic       wr_ready;
  logic [3:0] digit_hex;
  logic [2:0] digit_sel;
  logic       digit_dp;
  logic       digit_en;

  int checks = 0;
  int errors = 0;

  logic       en_seen [8];
  logic [3:0] raw_hex [8];
  logic       raw_dp  [8];

  frame_vec_t exp_tbl [4][8];

  always #5 clk = ~clk;

  sseg_scan_controller #(
    .PRESCALE_BITS(PB),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_mode  (wr_mode),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_dp    (wr_dp),
    .digit_hex(digit_hex),
    .digit_sel(digit_sel),
    .digit_dp (digit_dp),
    .digit_en (digit_en)
  );

  function automatic frame_vec_t fv(input logic en, input logic [3:0] hex, input logic dp);
    frame_vec_t r;
    r.en  = en;
    r.hex = hex;
    r.dp  = dp;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one write-port cycle starting at the next falling edge.
  task automatic apply_stimulus(input logic v, input logic clr, input logic mode,
                                input logic [2:0] addr, input logic [3:0] data, input logic dp);
    @(negedge clk);
    wr_valid = v;
    clear    = clr;
    wr_mode  = mode;
    wr_addr  = addr;
    wr_data  = data;
    wr_dp    = dp;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, WR_DIRECT, 3'd0, 4'd0, 1'b0);
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // Driver model: over one full frame, record what each digit position shows.
  task automatic capture_frame();
    for (int s = 0; s < 8; s++) begin
      en_seen[s] = 1'b0;
      raw_hex[s] = 4'hx;
      raw_dp[s]  = 1'bx;
    end
    for (int i = 0; i < 66; i++) begin
      sample();
      if (i >= 2) begin
        en_seen[digit_sel] = en_seen[digit_sel] | digit_en;
        raw_hex[digit_sel] = digit_hex;
        raw_dp[digit_sel]  = digit_dp;
      end
    end
  endtask

  task automatic check_frame(input int t, input string tag);
    for (int s = 0; s < 8; s++) begin
      check_output($sformatf("%s_en%0d", tag, s), 32'(en_seen[s]), 32'(exp_tbl[t][s].en));
      check_output($sformatf("%s_hex%0d", tag, s), 32'(raw_hex[s]), 32'(exp_tbl[t][s].hex));
      check_output($sformatf("%s_dp%0d", tag, s), 32'(raw_dp[s]), 32'(exp_tbl[t][s].dp));
    end
  endtask

  // Returns at the first sample after digit_sel changes to s.
  task automatic wait_sel(input logic [2:0] s, output logic ok);
    logic [2:0] prev;
    prev = digit_sel;
    ok   = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      sample();
      if (digit_sel == s && prev != s) ok = 1'b1;
      prev = digit_sel;
    end
  endtask

  initial begin
    logic ok;

    exp_tbl[0] = '{fv(1,4'hA,1), fv(0,4'h0,0), fv(0,4'h0,0), fv(0,4'h0,0),
                   fv(0,4'h0,0), fv(1,4'h3,0), fv(0,4'h0,0), fv(0,4'h0,0)};
    exp_tbl[1] = '{fv(1,4'h9,0), fv(1,4'h8,0), fv(1,4'h7,0), fv(1,4'h6,0),
                   fv(1,4'h5,0), fv(1,4'h4,0), fv(1,4'h3,0), fv(1,4'h2,0)};
    exp_tbl[2] = '{fv(0,4'h9,0), fv(0,4'h8,0), fv(1,4'hC,1), fv(0,4'h6,0),
                   fv(0,4'h5,0), fv(0,4'h4,0), fv(0,4'h3,0), fv(0,4'h2,0)};
    exp_tbl[3] = '{fv(0,4'h0,0), fv(0,4'h0,0), fv(0,4'h0,0), fv(0,4'h0,0),
                   fv(0,4'h0,0), fv(0,4'h0,0), fv(0,4'h0,0), fv(0,4'h0,0)};

    // Reset held, then free scan with an empty buffer
    repeat (2) @(negedge clk);
    check_output("rst_ready", 32'(wr_ready), 32'd0);
    check_output("rst_sel", 32'(digit_sel), 32'd0);
    check_output("rst_en", 32'(digit_en), 32'd0);
    check_output("rst_hex", 32'(digit_hex), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 72; k++) begin
      sample();
      check_output($sformatf("scan_sel_k%0d", k), 32'(digit_sel), 32'(((k - 1) / 8) % 8));
      check_output($sformatf("scan_en_k%0d", k), 32'(digit_en), 32'd0);
    end
    check_output("idle_ready", 32'(wr_ready), 32'd1);

    // Direct writes
    apply_stimulus(1'b1, 1'b0, WR_DIRECT, 3'd0, 4'hA, 1'b1);
    apply_stimulus(1'b1, 1'b0, WR_DIRECT, 3'd5, 4'h3, 1'b0);
    idle();
    capture_frame();
    check_frame(0, "direct");

    // Blank clock lands on the last output cycle of each dwell
    wait_sel(3'd0, ok);
    check_output("wait_sel0", 32'(ok), 32'd1);
    check_output("dwell0_first_en", 32'(digit_en), 32'd1);
    check_output("dwell0_first_hex", 32'(digit_hex), 32'hA);
    repeat (6) sample();
    check_output("dwell0_s7_en", 32'(digit_en), 32'd1);
    sample();
    check_output("dwell0_s8_sel", 32'(digit_sel), 32'd0);
    check_output("dwell0_s8_en", 32'(digit_en), 32'd0);
    sample();
    check_output("dwell1_first_sel", 32'(digit_sel), 32'd1);
    check_output("dwell1_first_en", 32'(digit_en), 32'd0);

    // Nine back-to-back shift writes, value 1 falls off the end
    for (int n = 1; n <= 9; n++) begin
      apply_stimulus(1'b1, 1'b0, WR_SHIFT, 3'd7, 4'(n), 1'b0);
    end
    idle();
    capture_frame();
    check_frame(1, "shift");

    // clear collides with a write; next-cycle write is accepted
    apply_stimulus(1'b1, 1'b1, WR_DIRECT, 3'd3, 4'h7, 1'b1);
    #1;
    check_output("clear_ready", 32'(wr_ready), 32'd0);
    apply_stimulus(1'b1, 1'b0, WR_DIRECT, 3'd2, 4'hC, 1'b1);
    #1;
    check_output("post_clear_ready", 32'(wr_ready), 32'd1);
    idle();
    capture_frame();
    check_frame(2, "clear");

    // Overwrite the digit currently on display
    wait_sel(3'd2, ok);
    check_output("wait_sel2", 32'(ok), 32'd1);
    apply_stimulus(1'b1, 1'b0, WR_DIRECT, 3'd2, 4'h1, 1'b0);
    sample();
    wr_valid = 1'b0;
    check_output("live_pre_hex", 32'(digit_hex), 32'hC);
    sample();
    check_output("live_post_hex", 32'(digit_hex), 32'h1);
    check_output("live_post_dp", 32'(digit_dp), 32'd0);
    check_output("live_post_sel", 32'(digit_sel), 32'd2);
    check_output("live_post_en", 32'(digit_en), 32'd1);

    // Async reset mid-dwell with a write pending
    wait_sel(3'd4, ok);
    check_output("wait_sel4", 32'(ok), 32'd1);
    sample();
    sample();
    wr_valid = 1'b1;
    wr_mode  = WR_DIRECT;
    wr_addr  = 3'd4;
    wr_data  = 4'hF;
    wr_dp    = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_output("midrst_sel", 32'(digit_sel), 32'd0);
    check_output("midrst_hex", 32'(digit_hex), 32'd0);
    check_output("midrst_en", 32'(digit_en), 32'd0);
    check_output("midrst_ready", 32'(wr_ready), 32'd0);
    repeat (2) @(negedge clk);
    wr_valid = 1'b0;
    reset    = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      sample();
      if (k == 1 || k == 8) check_output($sformatf("restart_sel_k%0d", k), 32'(digit_sel), 32'd0);
      if (k == 9) check_output("restart_sel_k9", 32'(digit_sel), 32'd1);
    end
    capture_frame();
    check_frame(3, "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
